deque_arbiter: RTL
==================

Name: deque_arbiter

Overview:
- Sequences single operations onto the shared dual-deque datapath and shares it between two requesters with valid/ready handshakes.
- Owns the shared deque_select, end_select, push and pop controls. Presents select/end one cycle ahead of each push/pop, because the deque registers the end selection.
- Checks full/empty before issuing, captures read data and returns a per-requester response.

Parameters:
- RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a command
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_op  in  2  00 PEEK, 01 PUSH, 10 POP, 11 REPLACE
- req0_deque  in  1  target deque (0/1)
- req0_end  in  1  0 front, 1 back
- req0_data  in  8  push/replace data
- req1_valid, req1_ready, req1_op, req1_deque, req1_end, req1_data  as requester 0
- resp0_valid  out  1  one-cycle response pulse to requester 0
- resp1_valid  out  1  one-cycle response pulse to requester 1
- resp_data  out  8  read data, shared by both responses
- resp_err  out  1  command refused (full/empty), qualified by respN_valid
- busy  out  1  FSM not in IDLE
- dq_select  out  1  to deque_select
- dq_end  out  1  to end_select
- dq_push  out  1  to push
- dq_pop  out  1  to pop
- dq_data_in  out  8  to data_in
- dq_data_out  in  8  from selected deque data_out
- dq_empty  in  2  empty flag of deque 1/0
- dq_full  in  2  full flag of deque 1/0

Behaviour:
- Reset values (async assert, sync release): state IDLE, all outputs 0, last_grant = 1 (requester 0 wins first tie), latched command cleared.
- FSM IDLE -> SETUP -> EXEC -> RESP -> IDLE.
- Cost is 4 cycles per command; no overlap.
- IDLE:
  - reqN_ready is combinational and equals the grant, asserted only in IDLE.
  - Grant rules:
    - Only one valid: that requester.
    - Both valid, RR_EN=1: the requester not equal to last_grant.
    - Both valid, RR_EN=0: requester 0.
  - On grant: latch op/deque/end/data, update last_grant, go to SETUP.
  - No valid: stay in IDLE. dq_select/dq_end hold the last issued values; dq_push = dq_pop = 0.
- SETUP:
  - dq_select = latched deque, dq_end = latched end, push = pop = 0.
  - dq_data_in = latched data, held through EXEC.
- EXEC:
  - select/end held.
  - Flags used are those of the latched deque: E = dq_empty[deque], F = dq_full[deque].
  - PUSH: if F, err and no push; else dq_push = 1.
  - POP: if E, err; else dq_pop = 1 and capture dq_data_out.
  - PEEK: if E, err; else capture dq_data_out, no push/pop.
  - REPLACE: if E, err; else dq_push = dq_pop = 1 (top overwritten in place) and capture the old top from dq_data_out.
  - Capture happens at the EXEC clock edge (value before the write takes effect).
- RESP:
  - respN_valid = 1 for exactly one cycle, for the granted requester only.
  - resp_data = captured value for PEEK/POP/REPLACE; 0 for PUSH or on err.
  - resp_err per the EXEC checks.
  - No backpressure on responses.
- resp_data/resp_err hold their values until the next RESP.
- A requester may re-assert valid in its own RESP cycle; it is considered in the following IDLE cycle.
- Wrap-around and pointer handling are entirely inside the deque; the arbiter never inspects pointers.
- Reset mid-command: the command is dropped with no response and dq_push/dq_pop deassert immediately. The requester must reissue.
- Requester inputs are ignored outside IDLE; held valid waits.

Test Plan:
- Reset, then req0 PUSH deque0 front 0x11 -> ready0 in cycle 0; SETUP cycle 1 (select 0, end 0, no push); dq_push=1 in cycle 2; resp0_valid in cycle 3 with err=0, data=0.
- Push 0xA1, 0xA2 to deque1 back, then POP deque1 back -> resp_data=0xA2, err=0; second POP -> 0xA1; third POP -> err=1, data=0, dq_pop never asserted.
- Fill deque0 to capacity (16 pushes), 17th PUSH -> err=1, dq_push never asserted, contents unchanged (verified by 16 POPs).
- Deque0 front holds 0x55; REPLACE 0x66 -> resp_data=0x55; PEEK -> 0x66 with size unchanged.
- Both requesters valid continuously, RR_EN=1 -> grants alternate 0,1,0,1; RR_EN=0 -> requester 0 always granted, requester 1 starves.
- rst_n asserted during EXEC of a PUSH -> all outputs 0 asynchronously, no resp pulse, FSM in IDLE after release, and a fresh PEEK completes normally.

Source files
------------

// File: rtl/deque_arbiter.sv
// Two-requester arbiter sequencing single ops onto a shared dual deque.
// Ports: req0/req1 valid-ready commands, resp0/resp1 pulses, dq_* datapath.
module deque_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic       req0_deque,
  input  logic       req0_end,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic       req1_deque,
  input  logic       req1_end,
  input  logic [7:0] req1_data,
  output logic       resp0_valid,
  output logic       resp1_valid,
  output logic [7:0] resp_data,
  output logic       resp_err,
  output logic       busy,
  output logic       dq_select,
  output logic       dq_end,
  output logic       dq_push,
  output logic       dq_pop,
  output logic [7:0] dq_data_in,
  input  logic [7:0] dq_data_out,
  input  logic [1:0] dq_empty,
  input  logic [1:0] dq_full
);

  localparam logic [1:0] OP_PEEK = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  typedef enum logic [1:0] {
    IDLE, SETUP, EXEC, RESP
  } state_t;

  state_t     state, state_nx;
  logic [1:0] cmd_op;
  logic       cmd_deque;
  logic       cmd_end;
  logic [7:0] cmd_data;
  logic       cmd_req;
  logic       last_grant;
  logic       gnt0, gnt1;
  logic       err_now;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        req0_valid && !req1_valid: gnt0 = 1'b1;
        !req0_valid && req1_valid: gnt1 = 1'b1;
        req0_valid && req1_valid: begin
          if (RR_EN) begin
            gnt0 = last_grant;
            gnt1 = !last_grant;
          end else begin
            gnt0 = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // PUSH is refused on full, every other op on empty
  always_comb begin
    if (cmd_op == OP_PUSH) err_now = dq_full[cmd_deque];
    else                   err_now = dq_empty[cmd_deque];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (gnt0 || gnt1) state_nx = SETUP;
      SETUP: state_nx = EXEC;
      EXEC:  state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_op     <= OP_PEEK;
      cmd_deque  <= 1'b0;
      cmd_end    <= 1'b0;
      cmd_data   <= '0;
      cmd_req    <= 1'b0;
      last_grant <= 1'b1;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        cmd_op     <= gnt1 ? req1_op    : req0_op;
        cmd_deque  <= gnt1 ? req1_deque : req0_deque;
        cmd_end    <= gnt1 ? req1_end   : req0_end;
        cmd_data   <= gnt1 ? req1_data  : req0_data;
        cmd_req    <= gnt1;
        last_grant <= gnt1;
      end
      // sample before the deque applies this cycle's write
      if (state == EXEC) begin
        resp_err <= err_now;
        if (err_now || cmd_op == OP_PUSH) resp_data <= '0;
        else                              resp_data <= dq_data_out;
      end
    end
  end

  always_comb begin
    req0_ready  = gnt0;
    req1_ready  = gnt1;
    busy        = (state != IDLE);
    resp0_valid = (state == RESP) && !cmd_req;
    resp1_valid = (state == RESP) && cmd_req;
    // select/end come from the latch so they hold between commands
    dq_select   = cmd_deque;
    dq_end      = cmd_end;
    dq_data_in  = '0;
    dq_push     = 1'b0;
    dq_pop      = 1'b0;
    if (state == SETUP || state == EXEC) dq_data_in = cmd_data;
    if (state == EXEC && !err_now) begin
      dq_push = (cmd_op == OP_PUSH) || (cmd_op == OP_REPL);
      dq_pop  = (cmd_op == OP_POP)  || (cmd_op == OP_REPL);
    end
  end

endmodule
